comp_unit: RTL and testbench



---
 rtl/comp_unit_pkg.sv | 26 ++
 rtl/comp_unit_core.sv | 40 ++++
 rtl/comp_unit.sv | 37 +++
 tb/tb_comp_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/comp_unit_pkg.sv
// Shared widths, funct3 encodings and field position for the branch comparator.
package comp_unit_pkg;

    localparam int XLEN  = 32;
    localparam int OPLEN = 8;

    // Position of funct3 inside the decoded opcode.
    localparam int F3_MSB = 6;
    localparam int F3_LSB = 4;
    localparam int F3_W   = F3_MSB - F3_LSB + 1;

    // funct3 encodings. 3'b011 is reserved and treated as don't-care.
    localparam logic [F3_W-1:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] FUNCT3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] FUNCT3_JUMP = 3'b010;
    localparam logic [F3_W-1:0] FUNCT3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] FUNCT3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] FUNCT3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] FUNCT3_BGEU = 3'b111;

    // Extract funct3 from a decoded opcode.
    function automatic logic [F3_W-1:0] get_funct3(input logic [OPLEN-1:0] op);
        return op[F3_MSB:F3_LSB];
    endfunction

endpackage

// File: rtl/comp_unit_core.sv
// Combinational compare/decode: picks the branch outcome selected by funct3.
module comp_core
    import comp_unit_pkg::*;
(
    input  logic [XLEN-1:0]  rs1data,
    input  logic [XLEN-1:0]  rs2data,
    input  logic [OPLEN-1:0] decoded_op,
    output logic             jump
);

    logic [F3_W-1:0] funct3;
    logic            eq;
    logic            lt_s;
    logic            lt_u;

    assign funct3 = get_funct3(decoded_op);

    // Three shared comparisons; every branch type is one of these or its complement.
    always_comb begin
        eq   = (rs1data == rs2data);
        lt_s = ($signed(rs1data) < $signed(rs2data));
        lt_u = (rs1data < rs2data);
    end

    // Select by funct3; reserved or unknown encodings yield X so synthesis may optimise them.
    always_comb begin
        jump = 1'bx;
        case (funct3)
            FUNCT3_BEQ:  jump = eq;
            FUNCT3_BNE:  jump = ~eq;
            FUNCT3_JUMP: jump = 1'b1;
            FUNCT3_BLT:  jump = lt_s;
            FUNCT3_BGE:  jump = ~lt_s;
            FUNCT3_BLTU: jump = lt_u;
            FUNCT3_BGEU: jump = ~lt_u;
            default:     jump = 1'bx;
        endcase
    end

endmodule

// File: rtl/comp_unit.sv
// Execute-stage branch comparator: combinational take flag plus a registered copy.
module comp_unit
    import comp_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  rs1data_de,
    input  logic [XLEN-1:0]  rs2data_de,
    input  logic [OPLEN-1:0] decoded_op_de,
    output logic             jump_state_pre,
    output logic             jump_state
);

    logic jump_state_d;
    logic jump_state_q;

    comp_core u_core (
        .rs1data    (rs1data_de),
        .rs2data    (rs2data_de),
        .decoded_op (decoded_op_de),
        .jump       (jump_state_pre)
    );

    // Next registered value is simply the current combinational decision.
    always_comb begin
        jump_state_d = jump_state_pre;
    end

    // Output flop, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) jump_state_q <= 1'b0;
        else     jump_state_q <= jump_state_d;
    end

    assign jump_state = jump_state_q;

endmodule

// File: tb/tb_comp_unit.sv
// Directed bench for comp_unit: vector table for the compare decode plus reset sequences.
module tb_comp_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs1, rs2;
    logic [7:0]  op;
    logic        pre, js;

    int checks   = 0;
    int failures = 0;

    comp_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rs1data_de     (rs1),
        .rs2data_de     (rs2),
        .decoded_op_de  (op),
        .jump_state_pre (pre),
        .jump_state     (js)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic probe;
        vecs[0]  = '{3'b000, 32'hA, 32'hA, 1'b1};
        vecs[1]  = '{3'b000, 32'hA, 32'h5, 1'b0};
        vecs[2]  = '{3'b001, 32'hA, 32'hA, 1'b0};
        vecs[3]  = '{3'b001, 32'hA, 32'h5, 1'b1};
        vecs[4]  = '{3'b010, 32'hA, 32'hA, 1'b1};
        vecs[5]  = '{3'b010, 32'hA, 32'h5, 1'b1};
        vecs[6]  = '{3'b100, 32'h80000008, 32'h1, 1'b1};
        vecs[7]  = '{3'b100, 32'h1, 32'h80000008, 1'b0};
        vecs[8]  = '{3'b100, 32'h80000001, 32'h80000008, 1'b1};
        vecs[9]  = '{3'b100, 32'h80000009, 32'h80000009, 1'b0};
        vecs[10] = '{3'b101, 32'h80000008, 32'h1, 1'b0};
        vecs[11] = '{3'b101, 32'h1, 32'h80000008, 1'b1};
        vecs[12] = '{3'b101, 32'h80000001, 32'h80000008, 1'b0};
        vecs[13] = '{3'b101, 32'h80000009, 32'h80000009, 1'b1};
        vecs[14] = '{3'b110, 32'h1, 32'h80000001, 1'b1};
        vecs[15] = '{3'b110, 32'h80000001, 32'h1, 1'b0};
        vecs[16] = '{3'b110, 32'h80000001, 32'h80000001, 1'b0};
        vecs[17] = '{3'b111, 32'h1, 32'h80000001, 1'b0};
        vecs[18] = '{3'b111, 32'h80000001, 32'h1, 1'b1};
        vecs[19] = '{3'b111, 32'h80000001, 32'h80000001, 1'b1};
        vecs[20] = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b1};
        vecs[21] = '{3'b110, 32'h80000000, 32'h7FFFFFFF, 1'b0};
        vecs[22] = '{3'b101, 32'h7FFFFFFF, 32'h80000000, 1'b1};
        vecs[23] = '{3'b111, 32'h7FFFFFFF, 32'h80000000, 1'b0};
        vecs[24] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[25] = '{3'b100, 32'hFFFFFFFF, 32'h0, 1'b1};

        // Reset held from time zero: register cleared, comb path live.
        rst = 1'b1;
        rs1 = 32'hA; rs2 = 32'hA; op = 8'h00;
        #2;
        chk("reset_js", js, 1'b0);
        chk("reset_pre_live", pre, 1'b1);
        @(posedge clk); #1;
        chk("reset_js_held", js, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("release_beq_js", js, 1'b1);

        // Table: bits outside funct3 are varied to show they are ignored.
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rs1 = vecs[i].a;
            rs2 = vecs[i].b;
            op = 8'h00;
            op[6:4] = vecs[i].f3;
            op[7] = i[0];
            op[3:0] = i[3:0];
            #1;
            chk($sformatf("vec%0d_pre", i), pre, vecs[i].exp);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_js", i), js, vecs[i].exp);
        end

        // Mid-cycle reset clears the register immediately, comb path untouched.
        @(negedge clk);
        rs1 = 32'h33; rs2 = 32'h33; op = 8'h00;
        @(posedge clk); #1;
        chk("mid_pre_set", js, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_js", js, 1'b0);
        chk("mid_rst_pre", pre, 1'b1);
        @(posedge clk); #1;
        chk("mid_rst_js_held", js, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_js", js, 1'b1);
        // Falling edge of the flag through the register (BNE on equal data).
        @(negedge clk); op = 8'h10;
        #1;
        chk("bne_eq_pre", pre, 1'b0);
        @(posedge clk); #1;
        chk("bne_eq_js", js, 1'b0);

        // Reserved / unknown funct3 only observable on a four-state simulator.
        probe = 1'bx;
        if (probe === 1'bx) begin
            @(negedge clk); op = 8'h30;
            #1;
            chk("rsvd_x", pre, 1'bx);
            op = 8'bxx0x_0xxx;
            #1;
            chk("f3_x", pre, 1'bx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
